// File: rtl/param_counter.sv
// Parametrised up/down counter with enable, direction, load/clear,
// wrap-or-saturate limits, terminal-count and wrap flags.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   defined   -> adds the prescale port and an internal prescaler;
//                a step happens every prescale+1 enabled cycles
//   undefined -> every enabled cycle is a step
//
// Ports:
//   clk        in  1           clock, all logic on posedge
//   rst_n      in  1           synchronous active-low reset
//   en         in  1           step qualifier
//   up_dn      in  1           1 = count up, 0 = count down
//   clear      in  1           synchronous clear to 0
//   load       in  1           synchronous load of load_value
//   load_value in  WIDTH       load value, clamped to MAX_VALUE
//   prescale   in  PRESCALE_W  prescale select (macro builds only)
//   count      out WIDTH       registered count
//   tc         out 1           terminal count for current direction
//   wrap       out 1           one-cycle pulse after a wrapping step
module param_counter #(
  parameter int unsigned     WIDTH      = 8,
  parameter longint unsigned MAX_VALUE  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP       = 1,
  parameter bit              SATURATE   = 1'b0,
  parameter int unsigned     PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap
);

  if (WIDTH < 2) begin : g_bad_width
    $error("param_counter: WIDTH must be >= 2");
  end
  if ((MAX_VALUE >> WIDTH) != 0) begin : g_bad_max
    $error("param_counter: MAX_VALUE must fit in WIDTH bits");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $error("param_counter: STEP must be in 1..MAX_VALUE");
  end
  if (PRESCALE_W < 1) begin : g_bad_psc
    $error("param_counter: PRESCALE_W must be >= 1");
  end

  // All limit arithmetic is carried one bit wider than the count so
  // overflow past MAX_VALUE is visible instead of truncated away.
  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [WIDTH:0] MAX_EXT =
    W1'(MAX_VALUE);
  localparam logic [WIDTH:0] STEP_EXT =
    W1'(STEP);
  localparam logic [WIDTH:0] MOD_EXT =
    MAX_EXT + W1'(1);
  localparam logic [WIDTH:0] DN_ADJ =
    MOD_EXT - STEP_EXT;
  localparam logic [WIDTH-1:0] MAX_CNT =
    WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_sum;
  logic             up_ovf;
  logic             dn_unf;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] ld_val;
  logic             step;

  assign cnt_ext = {1'b0, count};
  assign up_sum  = cnt_ext + STEP_EXT;
  // count + (MAX_VALUE+1) - STEP, with the constant part folded.
  assign dn_sum  = cnt_ext + DN_ADJ;
  assign up_ovf  = up_sum > MAX_EXT;
  assign dn_unf  = cnt_ext < STEP_EXT;

  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
    if (up_dn) begin
      if (!up_ovf) begin
        step_val = WIDTH'(up_sum);
      end else if (SATURATE) begin
        step_val = MAX_CNT;
      end else begin
        step_val  = WIDTH'(up_sum - MOD_EXT);
        step_wrap = 1'b1;
      end
    end else begin
      if (!dn_unf) begin
        step_val = WIDTH'(cnt_ext - STEP_EXT);
      end else if (SATURATE) begin
        step_val = '0;
      end else begin
        step_val  = WIDTH'(dn_sum);
        step_wrap = 1'b1;
      end
    end
  end

  assign ld_val = ({1'b0, load_value} > MAX_EXT)
                ? MAX_CNT : load_value;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q;
  logic [PRESCALE_W-1:0] psc_d;

  // Compare against the live prescale input so a new value is
  // picked up at the next compare without a restart.
  assign step = en && (psc_q == prescale);

  always_comb begin
    psc_d = psc_q;
    if (clear || load) begin
      psc_d = '0;
    end else if (en) begin
      psc_d = step ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  assign step = en;
`endif

  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ld_val;
    end else if (step) begin
      count_d = step_val;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

  assign tc = up_dn ? (count == MAX_CNT)
                    : (count == '0);

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: a vector table on two
// mod-10 step-3 instances plus directed sequences for limits.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lv8 = '0;
  logic [3:0] lv4 = '0;
`ifdef COUNTER_PRESCALE_EN
  logic [3:0] prescale = '0;
`endif

  logic [7:0] c0, c3;
  logic [3:0] c1, c2;
  logic       t0, t1, t2, t3;
  logic       w0, w1, w2, w3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_counter u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_value(lv8),
`ifdef COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(c0), .tc(t0), .wrap(w0)
  );

  param_counter #(
    .WIDTH(4), .MAX_VALUE(9), .STEP(3), .SATURATE(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_value(lv4),
`ifdef COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(c1), .tc(t1), .wrap(w1)
  );

  param_counter #(
    .WIDTH(4), .MAX_VALUE(9), .STEP(3), .SATURATE(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_value(lv4),
`ifdef COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(c2), .tc(t2), .wrap(w2)
  );

  param_counter #(
    .WIDTH(8), .MAX_VALUE(99)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
    .clear(clear), .load(load), .load_value(lv8),
`ifdef COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(c3), .tc(t3), .wrap(w3)
  );

  typedef struct {
    int rst_n, en, up, clr, ld, lv;
    int c1, w1, t1;
    int c2, w2, t2;
  } vec_t;

  vec_t tbl[19];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic chk0(input string tag,
                      input int c, input int w, input int t);
    check({tag, " u0 count"}, 32'(c0), c);
    check({tag, " u0 wrap"},  32'(w0), w);
    check({tag, " u0 tc"},    32'(t0), t);
  endtask

  task automatic chk3(input string tag,
                      input int c, input int w, input int t);
    check({tag, " u3 count"}, 32'(c3), c);
    check({tag, " u3 wrap"},  32'(w3), w);
    check({tag, " u3 tc"},    32'(t3), t);
  endtask

  task automatic chk2(input string tag,
                      input int c, input int w, input int t);
    check({tag, " u2 count"}, 32'(c2), c);
    check({tag, " u2 wrap"},  32'(w2), w);
    check({tag, " u2 tc"},    32'(t2), t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst en up clr ld lv  c1 w1 t1  c2 w2 t2
    tbl[0]  = '{1, 1, 1, 0, 0, 0,  3, 0, 0,  3, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0,  6, 0, 0,  6, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0,  9, 0, 1,  9, 0, 1};
    tbl[3]  = '{1, 1, 1, 0, 0, 0,  2, 1, 0,  9, 0, 1};
    tbl[4]  = '{1, 0, 1, 0, 0, 0,  2, 0, 0,  9, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 0, 0,  9, 1, 0,  6, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0,  6, 0, 0,  3, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0,  3, 0, 0,  0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 0, 0,  0, 0, 1,  0, 0, 1};
    tbl[9]  = '{1, 1, 0, 0, 0, 0,  7, 1, 0,  0, 0, 1};
    tbl[10] = '{1, 1, 1, 0, 1, 15, 9, 0, 1,  9, 0, 1};
    tbl[11] = '{1, 1, 1, 1, 1, 15, 0, 0, 0,  0, 0, 0};
    tbl[12] = '{1, 1, 1, 0, 0, 0,  3, 0, 0,  3, 0, 0};
    tbl[13] = '{1, 1, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0};
    tbl[14] = '{1, 1, 1, 0, 1, 5,  5, 0, 0,  5, 0, 0};
    tbl[15] = '{1, 1, 1, 0, 0, 0,  8, 0, 0,  8, 0, 0};
    tbl[16] = '{1, 1, 1, 0, 0, 0,  1, 1, 0,  9, 0, 1};
    tbl[17] = '{0, 1, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 1};

    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    chk0("reset", 0, 0, 0);
    check("reset u1 count", 32'(c1), 0);
    check("reset u3 wrap",  32'(w3), 0);

    for (int i = 0; i < 19; i++) begin
      rst_n = tbl[i].rst_n[0];
      en    = tbl[i].en[0];
      up_dn = tbl[i].up[0];
      clear = tbl[i].clr[0];
      load  = tbl[i].ld[0];
      lv4   = 4'(tbl[i].lv);
      tick();
      check($sformatf("vec%0d u1 count", i), 32'(c1), tbl[i].c1);
      check($sformatf("vec%0d u1 wrap", i),  32'(w1), tbl[i].w1);
      check($sformatf("vec%0d u1 tc", i),    32'(t1), tbl[i].t1);
      check($sformatf("vec%0d u2 count", i), 32'(c2), tbl[i].c2);
      check($sformatf("vec%0d u2 wrap", i),  32'(w2), tbl[i].w2);
      check($sformatf("vec%0d u2 tc", i),    32'(t2), tbl[i].t2);
    end
    clear = 1'b0;
    load  = 1'b0;

    // Saturating down count from 2 with step 3
    rst_n = 1'b1;
    load  = 1'b1;
    lv4   = 4'd2;
    tick();
    chk2("sat ld2", 2, 0, 0);
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b0;
    tick();
    chk2("sat dn1", 0, 0, 1);
    tick();
    chk2("sat dn2", 0, 0, 1);

    // Default 8-bit counter: 0,1,2.. then 255 -> 0 wraps
    rst_n = 1'b0;
    en    = 1'b0;
    up_dn = 1'b1;
    tick();
    tick();
    chk0("u0 rst", 0, 0, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk0($sformatf("u0 up%0d", i), i, 0, 0);
    end
    for (int i = 0; i < 252; i++) tick();
    chk0("u0 at255", 255, 0, 1);
    tick();
    chk0("u0 wrap0", 0, 1, 0);
    tick();
    chk0("u0 after", 1, 0, 0);

    // Reset in the middle of a count
    clear = 1'b1;
    tick();
    chk0("u0 clr", 0, 0, 0);
    clear = 1'b0;
    for (int i = 0; i < 57; i++) tick();
    chk0("u0 at57", 57, 0, 0);
    rst_n = 1'b0;
    tick();
    chk0("u0 midrst", 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk0("u0 resume", 1, 0, 0);

    // Load clamping on MAX_VALUE=99
    en   = 1'b0;
    load = 1'b1;
    lv8  = 8'd200;
    tick();
    chk3("ld200", 99, 0, 1);
    lv8  = 8'd100;
    tick();
    chk3("ld100", 99, 0, 1);
    clear = 1'b1;
    tick();
    chk3("ldclr", 0, 0, 0);
    clear = 1'b0;
    lv8   = 8'd42;
    tick();
    chk3("ld42", 42, 0, 0);
    lv8   = 8'd99;
    tick();
    chk3("ld99", 99, 0, 1);
    load  = 1'b0;
    en    = 1'b1;
    tick();
    chk3("wrap99", 0, 1, 0);
    en    = 1'b0;
    tick();
    chk3("hold", 0, 0, 0);

`ifdef COUNTER_PRESCALE_EN
    begin
      logic en_pat[7];
      int   exp_c[7];
      en_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      exp_c  = '{0, 0, 1, 1, 1, 1, 2};
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      prescale = 4'd2;
      for (int i = 0; i < 7; i++) begin
        en = en_pat[i];
        tick();
        check($sformatf("psc%0d u0 count", i), 32'(c0), exp_c[i]);
      end
      en       = 1'b0;
      prescale = 4'd0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
